rob_commit_ctrl: RTL and testbench

//  Retirement sequencer at the ROB read port: inspects the ROB head each cycle, retires it in order.

---
 rtl/rob_commit_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_rob_commit_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_commit_ctrl.sv
// rtl/rob_commit_ctrl.sv - ROB head retirement sequencer: commit writes, irrevocable ops, traps/xRET, flushes.
module rob_commit_ctrl #(
  parameter int XLEN = 64
) (
  input  logic            clk_i,
  input  logic            arst_i,
  input  logic            rob_valid_i,
  input  logic            rob_complete_i,
  input  logic [XLEN-1:0] rob_pc_i,
  input  logic [XLEN-1:0] rob_data_i,
  input  logic [XLEN-1:0] rob_csrdata_i,
  input  logic [XLEN-1:0] rob_branchaddr_i,
  input  logic [11:0]     rob_exc_i,
  input  logic [7:0]      rob_ctl_i,
  input  logic [4:0]      rob_rdindex_i,
  input  logic [4:0]      rob_frdindex_i,
  input  logic [11:0]     rob_csrindex_i,
  input  logic [4:0]      rob_fflag_i,
  output logic            rob_ready_o,
  output logic [1:0]      rd_we_o,
  output logic [4:0]      rd_addr_o,
  output logic [XLEN-1:0] rd_data_o,
  output logic            csr_we_o,
  output logic [11:0]     csr_addr_o,
  output logic [XLEN-1:0] csr_data_o,
  output logic            fflag_we_o,
  output logic [4:0]      fflag_o,
  output logic            irrevo_req_o,
  input  logic            irrevo_done_i,
  input  logic [XLEN-1:0] irrevo_rdata_i,
  output logic            trap_valid_o,
  output logic [1:0]      trap_kind_o,
  output logic [3:0]      trap_cause_o,
  output logic [XLEN-1:0] trap_pc_o,
  input  logic            trap_ready_i,
  input  logic [XLEN-1:0] trap_target_i,
  output logic            flush_o,
  output logic [XLEN-1:0] flush_pc_o
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    IRREVO = 2'd1,
    TRAP   = 2'd2,
    FLUSH  = 2'd3
  } state_t;

  state_t          state, state_next;
  logic [XLEN-1:0] held_pc, held_pc_next;
  logic [1:0]      kind, kind_next;
  logic [3:0]      cause, cause_next;

  logic jump, mret, sret, irrevo, rden, frden, csren, fflagen;
  assign {jump, mret, sret, irrevo, rden, frden, csren, fflagen} = rob_ctl_i;

  // Reset is folded into head so nothing retires while the block is held in reset.
  logic head;
  assign head = rob_valid_i & rob_complete_i & ~arst_i;

  logic [3:0] exc_code;
  always_comb begin
    exc_code = 4'd0;
    if      (rob_exc_i[11]) exc_code = 4'd0;
    else if (rob_exc_i[10]) exc_code = 4'd12;
    else if (rob_exc_i[9])  exc_code = 4'd1;
    else if (rob_exc_i[8])  exc_code = 4'd2;
    else if (rob_exc_i[7])  exc_code = 4'd3;
    else if (rob_exc_i[6])  exc_code = 4'd8;
    else if (rob_exc_i[5])  exc_code = 4'd4;
    else if (rob_exc_i[4])  exc_code = 4'd6;
    else if (rob_exc_i[3])  exc_code = 4'd13;
    else if (rob_exc_i[2])  exc_code = 4'd15;
    else if (rob_exc_i[1])  exc_code = 4'd5;
    else if (rob_exc_i[0])  exc_code = 4'd7;
  end

  logic            commit;
  logic [XLEN-1:0] commit_data;

  always_comb begin
    state_next   = state;
    held_pc_next = held_pc;
    kind_next    = kind;
    cause_next   = cause;
    commit       = 1'b0;
    commit_data  = rob_data_i;
    rob_ready_o  = 1'b0;
    irrevo_req_o = 1'b0;
    trap_valid_o = 1'b0;
    trap_kind_o  = 2'd0;
    trap_cause_o = 4'd0;
    trap_pc_o    = '0;
    flush_o      = 1'b0;
    flush_pc_o   = '0;

    case (state)
      RUN: begin
        if (head) begin
          if (|rob_exc_i) begin
            kind_next    = 2'd0;
            cause_next   = exc_code;
            held_pc_next = rob_pc_i;
            state_next   = TRAP;
          end else if (mret || sret) begin
            kind_next    = mret ? 2'd1 : 2'd2;
            cause_next   = 4'd0;
            held_pc_next = rob_pc_i;
            state_next   = TRAP;
          end else if (irrevo) begin
            held_pc_next = rob_pc_i;
            state_next   = IRREVO;
          end else begin
            commit      = 1'b1;
            rob_ready_o = 1'b1;
            if (jump) begin
              flush_o    = 1'b1;
              flush_pc_o = rob_branchaddr_i;
              state_next = FLUSH;
            end else if (csren) begin
              // CSR side effects may change fetch/translation state, so refetch.
              flush_o    = 1'b1;
              flush_pc_o = rob_pc_i + XLEN'(4);
              state_next = FLUSH;
            end
          end
        end
      end

      IRREVO: begin
        irrevo_req_o = 1'b1;
        if (irrevo_done_i) begin
          commit      = 1'b1;
          commit_data = irrevo_rdata_i;
          rob_ready_o = 1'b1;
          flush_o     = 1'b1;
          flush_pc_o  = held_pc + XLEN'(4);
          state_next  = FLUSH;
        end
      end

      TRAP: begin
        trap_valid_o = 1'b1;
        trap_kind_o  = kind;
        trap_cause_o = cause;
        trap_pc_o    = held_pc;
        if (trap_ready_i) begin
          rob_ready_o = 1'b1;
          flush_o     = 1'b1;
          flush_pc_o  = trap_target_i;
          state_next  = FLUSH;
        end
      end

      FLUSH: state_next = RUN;

      default: state_next = RUN;
    endcase
  end

  // Architectural writes for a retiring head; x0 is hardwired so its write is dropped, f0 is not.
  always_comb begin
    rd_we_o    = 2'b00;
    rd_addr_o  = 5'd0;
    rd_data_o  = '0;
    csr_we_o   = 1'b0;
    csr_addr_o = 12'd0;
    csr_data_o = '0;
    fflag_we_o = 1'b0;
    fflag_o    = 5'd0;
    if (commit) begin
      rd_we_o    = {frden, rden & (|rob_rdindex_i)};
      rd_addr_o  = frden ? rob_frdindex_i : rob_rdindex_i;
      rd_data_o  = commit_data;
      csr_we_o   = csren;
      csr_addr_o = rob_csrindex_i;
      csr_data_o = rob_csrdata_i;
      fflag_we_o = fflagen;
      fflag_o    = rob_fflag_i;
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state   <= RUN;
      held_pc <= '0;
      kind    <= 2'd0;
      cause   <= 4'd0;
    end else begin
      state   <= state_next;
      held_pc <= held_pc_next;
      kind    <= kind_next;
      cause   <= cause_next;
    end
  end

endmodule

// File: tb/tb_rob_commit_ctrl.sv
// tb/tb_rob_commit_ctrl.sv - scoreboard bench for rob_commit_ctrl with a retirement reference model.
module tb_rob_commit_ctrl;
  localparam int XLEN = 64;

  logic            clk_i = 1'b0;
  logic            arst_i = 1'b1;
  logic            rob_valid_i = 1'b0, rob_complete_i = 1'b0;
  logic [XLEN-1:0] rob_pc_i = '0, rob_data_i = '0, rob_csrdata_i = '0, rob_branchaddr_i = '0;
  logic [11:0]     rob_exc_i = '0;
  logic [7:0]      rob_ctl_i = '0;
  logic [4:0]      rob_rdindex_i = '0, rob_frdindex_i = '0, rob_fflag_i = '0;
  logic [11:0]     rob_csrindex_i = '0;
  logic            rob_ready_o;
  logic [1:0]      rd_we_o;
  logic [4:0]      rd_addr_o;
  logic [XLEN-1:0] rd_data_o;
  logic            csr_we_o;
  logic [11:0]     csr_addr_o;
  logic [XLEN-1:0] csr_data_o;
  logic            fflag_we_o;
  logic [4:0]      fflag_o;
  logic            irrevo_req_o;
  logic            irrevo_done_i = 1'b0;
  logic [XLEN-1:0] irrevo_rdata_i = '0;
  logic            trap_valid_o;
  logic [1:0]      trap_kind_o;
  logic [3:0]      trap_cause_o;
  logic [XLEN-1:0] trap_pc_o;
  logic            trap_ready_i = 1'b0;
  logic [XLEN-1:0] trap_target_i = '0;
  logic            flush_o;
  logic [XLEN-1:0] flush_pc_o;

  always #5 clk_i = ~clk_i;

  rob_commit_ctrl #(.XLEN(XLEN)) dut (
    .clk_i(clk_i), .arst_i(arst_i),
    .rob_valid_i(rob_valid_i), .rob_complete_i(rob_complete_i),
    .rob_pc_i(rob_pc_i), .rob_data_i(rob_data_i), .rob_csrdata_i(rob_csrdata_i),
    .rob_branchaddr_i(rob_branchaddr_i), .rob_exc_i(rob_exc_i), .rob_ctl_i(rob_ctl_i),
    .rob_rdindex_i(rob_rdindex_i), .rob_frdindex_i(rob_frdindex_i),
    .rob_csrindex_i(rob_csrindex_i), .rob_fflag_i(rob_fflag_i),
    .rob_ready_o(rob_ready_o), .rd_we_o(rd_we_o), .rd_addr_o(rd_addr_o), .rd_data_o(rd_data_o),
    .csr_we_o(csr_we_o), .csr_addr_o(csr_addr_o), .csr_data_o(csr_data_o),
    .fflag_we_o(fflag_we_o), .fflag_o(fflag_o),
    .irrevo_req_o(irrevo_req_o), .irrevo_done_i(irrevo_done_i), .irrevo_rdata_i(irrevo_rdata_i),
    .trap_valid_o(trap_valid_o), .trap_kind_o(trap_kind_o), .trap_cause_o(trap_cause_o),
    .trap_pc_o(trap_pc_o), .trap_ready_i(trap_ready_i), .trap_target_i(trap_target_i),
    .flush_o(flush_o), .flush_pc_o(flush_pc_o)
  );

  typedef struct {
    logic [63:0] pc, data, csrdata, branch;
    logic [11:0] exc;
    logic [7:0]  ctl;
    logic [4:0]  rd, frd, fflag;
    logic [11:0] csr;
  } entry_t;

  typedef struct {
    logic        is_trap;
    logic [1:0]  kind;
    logic [3:0]  cause;
    logic [63:0] tpc;
    logic [1:0]  rd_we;
    logic [4:0]  rd_addr;
    logic [63:0] rd_data;
    logic        csr_we;
    logic [11:0] csr_addr;
    logic [63:0] csr_data;
    logic        fflag_we;
    logic [4:0]  fflag;
    logic        flush;
    logic [63:0] flush_pc;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  logic prev_flush = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, want, $time);
    end
  endtask

  // Retirement outcome of one head entry, straight from the architectural rules.
  function automatic exp_t model(entry_t e, logic [63:0] target, logic [63:0] rdata);
    int   code_of_bit[12] = '{7, 5, 15, 13, 6, 4, 8, 3, 2, 1, 12, 0};
    bit   jump = e.ctl[7], mret = e.ctl[6], sret = e.ctl[5], irrevo = e.ctl[4];
    bit   rden = e.ctl[3], frden = e.ctl[2], csren = e.ctl[1], fflagen = e.ctl[0];
    exp_t x;
    x = '{default: '0};
    if (e.exc != 0) begin
      x.is_trap = 1; x.kind = 0; x.tpc = e.pc;
      for (int i = 0; i < 12; i++) if (e.exc[i]) x.cause = 4'(code_of_bit[i]);
      x.flush = 1; x.flush_pc = target;
    end else if (mret || sret) begin
      x.is_trap = 1; x.kind = mret ? 2'd1 : 2'd2; x.tpc = e.pc;
      x.flush = 1; x.flush_pc = target;
    end else begin
      x.rd_we    = {frden, rden && (e.rd != 0)};
      x.rd_addr  = frden ? e.frd : e.rd;
      x.rd_data  = irrevo ? rdata : e.data;
      x.csr_we   = csren;   x.csr_addr = e.csr; x.csr_data = e.csrdata;
      x.fflag_we = fflagen; x.fflag = e.fflag;
      if (irrevo)     begin x.flush = 1; x.flush_pc = e.pc + 64'd4; end
      else if (jump)  begin x.flush = 1; x.flush_pc = e.branch; end
      else if (csren) begin x.flush = 1; x.flush_pc = e.pc + 64'd4; end
    end
    return x;
  endfunction

  always @(negedge clk_i) begin
    if (arst_i) prev_flush = 1'b0;
    else begin
      if (prev_flush) check("pop_in_flush_cycle", 64'(rob_ready_o), 0);
      if (trap_valid_o) begin
        if (exp_q.size() == 0) check("trap_without_entry", 64'(trap_valid_o), 0);
        else begin
          check("trap_expected", 64'(exp_q[0].is_trap), 1);
          check("trap_kind", 64'(trap_kind_o), 64'(exp_q[0].kind));
          check("trap_cause", 64'(trap_cause_o), 64'(exp_q[0].cause));
          check("trap_pc", trap_pc_o, exp_q[0].tpc);
        end
      end
      if (rob_ready_o) begin
        if (exp_q.size() == 0) check("pop_unexpected", 64'(rob_ready_o), 0);
        else begin
          exp_t x;
          x = exp_q.pop_front();
          check("rd_we", 64'(rd_we_o), 64'(x.rd_we));
          if (x.rd_we != 0) begin
            check("rd_addr", 64'(rd_addr_o), 64'(x.rd_addr));
            check("rd_data", rd_data_o, x.rd_data);
          end
          check("csr_we", 64'(csr_we_o), 64'(x.csr_we));
          if (x.csr_we) begin
            check("csr_addr", 64'(csr_addr_o), 64'(x.csr_addr));
            check("csr_data", csr_data_o, x.csr_data);
          end
          check("fflag_we", 64'(fflag_we_o), 64'(x.fflag_we));
          if (x.fflag_we) check("fflag", 64'(fflag_o), 64'(x.fflag));
          check("flush", 64'(flush_o), 64'(x.flush));
          if (x.flush) check("flush_pc", flush_pc_o, x.flush_pc);
        end
      end else if (flush_o) check("flush_without_pop", 64'(flush_o), 0);
      prev_flush = flush_o;
    end
  end

  task automatic drive(entry_t e);
    rob_pc_i = e.pc; rob_data_i = e.data; rob_csrdata_i = e.csrdata; rob_branchaddr_i = e.branch;
    rob_exc_i = e.exc; rob_ctl_i = e.ctl; rob_rdindex_i = e.rd; rob_frdindex_i = e.frd;
    rob_csrindex_i = e.csr; rob_fflag_i = e.fflag;
  endtask

  // Called at posedge+1; returns at posedge+1 of the cycle after the pop.
  task automatic run_entry(entry_t e, int incomplete, int irr_delay, int trap_delay,
                           logic [63:0] target, logic [63:0] rdata);
    int reqcnt = 0, tcnt = 0;
    bit done = 0;
    drive(e);
    rob_valid_i = 1; rob_complete_i = 0;
    for (int k = 0; k < incomplete; k++) begin
      @(negedge clk_i);
      check("incomplete_no_pop", 64'(rob_ready_o), 0);
      @(posedge clk_i); #1;
    end
    rob_complete_i = 1;
    exp_q.push_back(model(e, target, rdata));
    for (int c = 0; c < 60 && !done; c++) begin
      irrevo_done_i = 0; irrevo_rdata_i = ~rdata;
      trap_ready_i = 0;  trap_target_i = ~target;
      if (irrevo_req_o) begin
        reqcnt++;
        if (reqcnt == irr_delay) begin irrevo_done_i = 1; irrevo_rdata_i = rdata; end
      end
      if (trap_valid_o) begin
        tcnt++;
        if (tcnt == trap_delay) begin trap_ready_i = 1; trap_target_i = target; end
      end
      @(negedge clk_i);
      if (rob_ready_o) done = 1;
      @(posedge clk_i); #1;
    end
    irrevo_done_i = 0; trap_ready_i = 0;
    rob_valid_i = 0; rob_complete_i = 0;
    if (!done) begin
      check("retire_timeout", 64'(done), 1);
      exp_q.delete();
    end else if (e.exc == 0 && e.ctl[6:5] == 0 && e.ctl[4])
      check("irrevo_req_cycles", 64'(reqcnt), 64'(irr_delay));
  endtask

  function automatic entry_t mk(logic [63:0] pc, logic [7:0] ctl, logic [11:0] exc, logic [4:0] rd,
                                logic [4:0] frd, logic [63:0] data, logic [63:0] branch);
    entry_t e;
    e = '{default: '0};
    e.pc = pc; e.ctl = ctl; e.exc = exc; e.rd = rd; e.frd = frd; e.data = data; e.branch = branch;
    e.csr = 12'h300; e.csrdata = 64'hC5C5; e.fflag = 5'h1f;
    return e;
  endfunction

  function automatic entry_t rand_entry();
    entry_t e;
    int     k = int'($urandom_range(0, 9));
    e.pc = ($urandom_range(0, 7) == 0) ? 64'hFFFF_FFFF_FFFF_FFFC : {$urandom, $urandom} & ~64'h3;
    e.data = {$urandom, $urandom}; e.csrdata = {$urandom, $urandom}; e.branch = {$urandom, $urandom};
    e.ctl = 8'($urandom); e.exc = 12'd0;
    e.rd = 5'($urandom); e.frd = 5'($urandom); e.fflag = 5'($urandom); e.csr = 12'($urandom);
    if ($urandom_range(0, 3) == 0) e.rd = 5'd0;
    if (k < 2) e.exc = 12'($urandom_range(1, 4095));
    else if (k == 2) e.ctl[6:5] = $urandom_range(0, 1) ? 2'b10 : 2'b01;
    else if (k < 5) begin e.ctl[6:5] = 2'b00; e.ctl[4] = 1'b1; end
    else e.ctl[6:4] = 3'b000;
    return e;
  endfunction

  initial begin
    entry_t e;
    // Hold reset with a ready head: nothing may retire or be requested.
    drive(mk(64'h1000, 8'h08, 12'h0, 5'd5, 5'd0, 64'hAA, 64'h0));
    rob_valid_i = 1; rob_complete_i = 1;
    @(negedge clk_i);
    check("reset_pop", 64'(rob_ready_o), 0);
    check("reset_rd_we", 64'(rd_we_o), 0);
    check("reset_flush", 64'(flush_o), 0);
    check("reset_trap_valid", 64'(trap_valid_o), 0);
    check("reset_irrevo_req", 64'(irrevo_req_o), 0);
    rob_valid_i = 0; rob_complete_i = 0;
    @(posedge clk_i); #1; arst_i = 0;
    @(posedge clk_i); #1;

    run_entry(mk(64'h1000, 8'h08, 12'h0, 5'd5, 5'd0, 64'hAA, 64'h0), 1, 1, 1, 64'h0, 64'h0);
    run_entry(mk(64'h1004, 8'h08, 12'h0, 5'd0, 5'd9, 64'hBB, 64'h0), 0, 1, 1, 64'h0, 64'h0);
    run_entry(mk(64'h1008, 8'h04, 12'h0, 5'd3, 5'd0, 64'hCC, 64'h0), 0, 1, 1, 64'h0, 64'h0);
    run_entry(mk(64'h2000, 8'h08, 12'h102, 5'd1, 5'd0, 64'h0, 64'h0), 0, 1, 3, 64'h80, 64'h0);
    run_entry(mk(64'h3000, 8'h18, 12'h0, 5'd7, 5'd0, 64'h0, 64'h0), 0, 5, 1, 64'h0, 64'h55);
    run_entry(mk(64'h3100, 8'h88, 12'h0, 5'd2, 5'd0, 64'h11, 64'h4000), 0, 1, 1, 64'h0, 64'h0);
    run_entry(mk(64'h4000, 8'h08, 12'h0, 5'd4, 5'd0, 64'h22, 64'h0), 0, 1, 1, 64'h0, 64'h0);
    run_entry(mk(64'h5000, 8'h40, 12'h0, 5'd0, 5'd0, 64'h0, 64'h0), 0, 1, 2, 64'h9000, 64'h0);
    run_entry(mk(64'h5100, 8'h20, 12'h0, 5'd0, 5'd0, 64'h0, 64'h0), 0, 1, 1, 64'h9100, 64'h0);
    run_entry(mk(64'hFFFF_FFFF_FFFF_FFFC, 8'h0B, 12'h0, 5'd6, 5'd0, 64'h33, 64'h0), 0, 1, 1, 64'h0, 64'h0);
    run_entry(mk(64'h6000, 8'h00, 12'h040, 5'd0, 5'd0, 64'h0, 64'h0), 0, 1, 1, 64'h100, 64'h0);

    // Reset while a trap waits for the CSR unit.
    e = mk(64'h7000, 8'h00, 12'h100, 5'd0, 5'd0, 64'h0, 64'h0);
    drive(e); rob_valid_i = 1; rob_complete_i = 1;
    exp_q.push_back(model(e, 64'h0, 64'h0));
    for (int c = 0; c < 20 && !trap_valid_o; c++) begin @(posedge clk_i); #1; end
    check("trap_raised_before_reset", 64'(trap_valid_o), 1);
    @(posedge clk_i); #2;
    arst_i = 1;
    #1;
    check("reset_drops_trap_valid", 64'(trap_valid_o), 0);
    exp_q.delete();
    rob_valid_i = 0; rob_complete_i = 0;
    @(posedge clk_i); #1; arst_i = 0;
    @(negedge clk_i);
    check("post_reset_no_pop", 64'(rob_ready_o), 0);
    check("post_reset_trap_valid", 64'(trap_valid_o), 0);
    @(posedge clk_i); #1;
    run_entry(mk(64'h7100, 8'h08, 12'h0, 5'd8, 5'd0, 64'h77, 64'h0), 0, 1, 1, 64'h0, 64'h0);

    for (int n = 0; n < 250; n++) begin
      int gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) begin @(posedge clk_i); #1; end
      run_entry(rand_entry(), int'($urandom_range(0, 2)), int'($urandom_range(1, 4)),
                int'($urandom_range(1, 4)), {$urandom, $urandom}, {$urandom, $urandom});
    end
    repeat (3) @(posedge clk_i);
    check("queue_drained", 64'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
